// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending transaction controller: coin credit, vend handshake, nickel change
//
// Accumulates credit from single-cycle coin pulses, requests a vend once the
// price is covered, and (optionally) pays back any remaining credit one nickel
// at a time through the change hopper.
//
// Optional feature macro: VEND_CHANGE_EN
//   defined   : CHANGE state, chg_req, cancel-refund and change after vend/timeout
//   undefined : no CHANGE state, chg_req tied 0, cancel/chg_ack ignored,
//               leftover credit is carried over in IDLE
//
// Parameters:
//   PRICE      item price in cents (multiple of 5, >= 5, <= MAX_CREDIT)
//   MAX_CREDIT credit ceiling in cents (multiple of 5, < 2**CREDIT_W)
//   CREDIT_W   credit register width
//   TIMEOUT    max cycles vend_req may stay high without vend_ack (>= 2)
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   N, D, Q     in   nickel / dime / quarter pulses, one cycle per coin
//   cancel      in   refund request level
//   vend_ack    in   dispenser done, meaningful only while vend_req=1
//   chg_ack     in   one nickel ejected, meaningful only while chg_req=1
//   credit      out  current credit in cents
//   vend_req    out  dispense request
//   chg_req     out  eject-one-nickel request
//   coin_reject out  one-cycle pulse, coin refused and credit unchanged
//   busy        out  high in VEND or CHANGE
//   fault       out  one-cycle pulse on vend timeout

module vend_ctrl #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 60,
    parameter int CREDIT_W   = 7,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic                chg_req,
    output logic                coin_reject,
    output logic                busy,
    output logic                fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] ZERO     = '0;
    localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(TIMEOUT - 1);

`ifdef VEND_CHANGE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1
    } state_t;
`endif

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;

    logic [1:0]           coin_cnt;
    logic                 any_coin;
    logic [CREDIT_W:0]    coin_val;
    logic [CREDIT_W:0]    credit_sum;
    logic                 coin_ok;

    // Coin decode. The sum is one bit wider than credit so the ceiling
    // comparison cannot wrap even for a quarter on top of MAX_CREDIT.
    assign coin_cnt   = {1'b0, N} + {1'b0, D} + {1'b0, Q};
    assign any_coin   = N | D | Q;
    assign credit_sum = {1'b0, credit} + coin_val;
    assign coin_ok    = (coin_cnt == 2'd1) && (credit_sum <= MAX_EXT);

    always_comb begin
        coin_val = '0;
        if (N) begin
            coin_val = (CREDIT_W + 1)'(5);
        end else if (D) begin
            coin_val = (CREDIT_W + 1)'(10);
        end else if (Q) begin
            coin_val = (CREDIT_W + 1)'(25);
        end
    end

`ifndef VEND_CHANGE_EN
    // Without the change path these inputs have no function.
    logic unused_inputs;
    assign unused_inputs = cancel ^ chg_ack;
    assign chg_req       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            credit      <= '0;
            vend_req    <= 1'b0;
`ifdef VEND_CHANGE_EN
            chg_req     <= 1'b0;
`endif
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            coin_reject <= 1'b0;
            fault       <= 1'b0;

            case (state)
                IDLE: begin
                    // Coin acceptance and the state decision are independent:
                    // the decision looks only at the registered credit, so a
                    // coin accepted on the same edge is simply added on top.
                    if (any_coin) begin
                        if (coin_ok) begin
                            credit <= credit_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end

                    if (credit >= PRICE_C) begin
                        state    <= VEND;
                        wait_cnt <= '0;
                        vend_req <= 1'b1;
                        busy     <= 1'b1;
                    end
`ifdef VEND_CHANGE_EN
                    else if (cancel && (credit != ZERO)) begin
                        state   <= CHANGE;
                        chg_req <= 1'b1;
                        busy    <= 1'b1;
                    end
`endif
                end

                VEND: begin
                    if (any_coin) begin
                        coin_reject <= 1'b1;
                    end

                    // Ack is checked first so that an ack on the timeout edge
                    // completes the sale and suppresses the fault.
                    if (vend_ack) begin
                        credit   <= credit - PRICE_C;
                        vend_req <= 1'b0;
`ifdef VEND_CHANGE_EN
                        if (credit != PRICE_C) begin
                            state   <= CHANGE;
                            chg_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
`endif
                    end else if (wait_cnt == TMO_LAST) begin
                        // This edge ends the TIMEOUT-th cycle of vend_req.
                        fault    <= 1'b1;
                        vend_req <= 1'b0;
`ifdef VEND_CHANGE_EN
                        if (credit != ZERO) begin
                            state   <= CHANGE;
                            chg_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

`ifdef VEND_CHANGE_EN
                CHANGE: begin
                    if (any_coin) begin
                        coin_reject <= 1'b1;
                    end

                    // One nickel per acknowledged cycle; the last one drops
                    // the request on the same edge that empties the credit.
                    if (chg_ack) begin
                        credit <= credit - NICKEL;
                        if (credit == NICKEL) begin
                            state   <= IDLE;
                            chg_req <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    vend_req <= 1'b0;
`ifdef VEND_CHANGE_EN
                    chg_req  <= 1'b0;
`endif
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl

module tb_vend_ctrl;

    logic       clk;
    logic       rstn;
    logic       N, D, Q;
    logic       cancel;
    logic       vend_ack;
    logic       chg_ack;
    logic [6:0] credit;
    logic       vend_req;
    logic       chg_req;
    logic       coin_reject;
    logic       busy;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    vend_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .N           (N),
        .D           (D),
        .Q           (Q),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .vend_req    (vend_req),
        .chg_req     (chg_req),
        .coin_reject (coin_reject),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        N = 0; D = 0; Q = 0;
        cancel = 0; vend_ack = 0; chg_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        N = n; D = d; Q = q;
        tick();
        N = 0; D = 0; Q = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (credit !== 7'd0 || vend_req !== 1'b0 || chg_req !== 1'b0 ||
            coin_reject !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got credit=%0d vreq=%b creq=%b rej=%b busy=%b fault=%b want all 0",
                     credit, vend_req, chg_req, coin_reject, busy, fault);
        end

        // Asynchronous reset in the middle of a vend.
        coin(0, 0, 1);
        tick();
        checks++;
        if (credit !== 7'd25 || vend_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_vend got credit=%0d vreq=%b want 25 1", credit, vend_req);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (credit !== 7'd0 || vend_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got credit=%0d vreq=%b busy=%b want 0 0 0", credit, vend_req, busy);
        end
        tick();
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if (vend_req !== 1'b0 || busy !== 1'b0 || credit !== 7'd0) begin
            failures++;
            $display("FAIL reset_idle_after got vreq=%b busy=%b credit=%0d want 0 0 0", vend_req, busy, credit);
        end
    endtask

    task automatic test_basic_vend();
        do_reset();
        coin(1, 0, 0);
        checks++;
        if (credit !== 7'd5) begin
            failures++;
            $display("FAIL basic_nickel credit got %0d want 5", credit);
        end
        coin(0, 1, 0);
        checks++;
        if (credit !== 7'd15 || vend_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_dime got credit=%0d vreq=%b want 15 0", credit, vend_req);
        end
        tick();
        checks++;
        if (vend_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_vreq got vreq=%b busy=%b want 1 1", vend_req, busy);
        end
        vend_ack = 1;
        tick();
        vend_ack = 0;
        checks++;
        if (credit !== 7'd0 || vend_req !== 1'b0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack got credit=%0d vreq=%b creq=%b busy=%b want 0 0 0 0",
                     credit, vend_req, chg_req, busy);
        end
        tick();
        checks++;
        if (vend_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_stay_idle got vreq=%b busy=%b want 0 0", vend_req, busy);
        end
    endtask

    task automatic test_change_after_vend();
        do_reset();
        coin(0, 0, 1);
        tick();
        tick();
        tick();
        checks++;
        if (vend_req !== 1'b1 || credit !== 7'd25) begin
            failures++;
            $display("FAIL chg_pre_ack got vreq=%b credit=%0d want 1 25", vend_req, credit);
        end
        vend_ack = 1;
        tick();
        vend_ack = 0;
`ifdef VEND_CHANGE_EN
        checks++;
        if (credit !== 7'd10 || vend_req !== 1'b0 || chg_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL chg_after_ack got credit=%0d vreq=%b creq=%b busy=%b want 10 0 1 1",
                     credit, vend_req, chg_req, busy);
        end
        chg_ack = 1;
        tick();
        checks++;
        if (credit !== 7'd5 || chg_req !== 1'b1) begin
            failures++;
            $display("FAIL chg_first_nickel got credit=%0d creq=%b want 5 1", credit, chg_req);
        end
        tick();
        checks++;
        if (credit !== 7'd0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL chg_done got credit=%0d creq=%b busy=%b want 0 0 0", credit, chg_req, busy);
        end
        tick();
        chg_ack = 0;
        checks++;
        if (credit !== 7'd0 || chg_req !== 1'b0) begin
            failures++;
            $display("FAIL chg_ack_ignored got credit=%0d creq=%b want 0 0", credit, chg_req);
        end
`else
        checks++;
        if (credit !== 7'd10 || vend_req !== 1'b0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL carry_after_ack got credit=%0d vreq=%b creq=%b busy=%b want 10 0 0 0",
                     credit, vend_req, chg_req, busy);
        end
        chg_ack = 1;
        tick();
        tick();
        chg_ack = 0;
        checks++;
        if (credit !== 7'd10 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL carry_kept got credit=%0d creq=%b busy=%b want 10 0 0", credit, chg_req, busy);
        end
`endif
    endtask

    task automatic test_coin_reject();
        do_reset();
        coin(1, 1, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 7'd0) begin
            failures++;
            $display("FAIL rej_multi got rej=%b credit=%0d want 1 0", coin_reject, credit);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin
            failures++;
            $display("FAIL rej_pulse_width got rej=%b want 0", coin_reject);
        end
        coin(0, 1, 0);
        coin(0, 0, 1);
        checks++;
        if (credit !== 7'd35 || vend_req !== 1'b0) begin
            failures++;
            $display("FAIL rej_build got credit=%0d vreq=%b want 35 0", credit, vend_req);
        end
        // 35 + 25 lands exactly on the ceiling and is accepted.
        coin(0, 0, 1);
        checks++;
        if (credit !== 7'd60 || coin_reject !== 1'b0 || vend_req !== 1'b1) begin
            failures++;
            $display("FAIL rej_max_ok got credit=%0d rej=%b vreq=%b want 60 0 1", credit, coin_reject, vend_req);
        end
        coin(0, 0, 1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 7'd60) begin
            failures++;
            $display("FAIL rej_in_vend got rej=%b credit=%0d want 1 60", coin_reject, credit);
        end
        vend_ack = 1;
        tick();
        vend_ack = 0;
        checks++;
        if (credit !== 7'd45 || vend_req !== 1'b0) begin
            failures++;
            $display("FAIL rej_after_ack got credit=%0d vreq=%b want 45 0", credit, vend_req);
        end
        // Another quarter: 45 + 25 exceeds the ceiling (macro off, IDLE) or
        // arrives during CHANGE (macro on); refused either way.
        coin(0, 0, 1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 7'd45) begin
            failures++;
            $display("FAIL rej_over_max got rej=%b credit=%0d want 1 45", coin_reject, credit);
        end
`ifndef VEND_CHANGE_EN
        checks++;
        if (vend_req !== 1'b1) begin
            failures++;
            $display("FAIL rej_carry_revend got vreq=%b want 1", vend_req);
        end
`endif
    endtask

    task automatic test_cancel();
        do_reset();
        coin(0, 1, 0);
        cancel = 1;
        tick();
`ifdef VEND_CHANGE_EN
        checks++;
        if (chg_req !== 1'b1 || busy !== 1'b1 || credit !== 7'd10) begin
            failures++;
            $display("FAIL cancel_enter got creq=%b busy=%b credit=%0d want 1 1 10", chg_req, busy, credit);
        end
        chg_ack = 1;
        tick();
        checks++;
        if (credit !== 7'd5 || chg_req !== 1'b1) begin
            failures++;
            $display("FAIL cancel_nickel1 got credit=%0d creq=%b want 5 1", credit, chg_req);
        end
        tick();
        chg_ack = 0;
        cancel = 0;
        checks++;
        if (credit !== 7'd0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_done got credit=%0d creq=%b busy=%b want 0 0 0", credit, chg_req, busy);
        end
`else
        tick();
        cancel = 0;
        checks++;
        if (credit !== 7'd10 || chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_ignored got credit=%0d creq=%b busy=%b want 10 0 0", credit, chg_req, busy);
        end
`endif
    endtask

    task automatic test_timeout();
        int early_err;
        do_reset();
        coin(0, 0, 1);
        tick();
        // After the edge ending each of vend_req cycles 1..15: still waiting.
        early_err = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (vend_req !== 1'b1 || fault !== 1'b0) early_err++;
        end
        checks++;
        if (early_err != 0) begin
            failures++;
            $display("FAIL tmo_early got %0d bad cycles want 0", early_err);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || vend_req !== 1'b0 || credit !== 7'd25) begin
            failures++;
            $display("FAIL tmo_fire got fault=%b vreq=%b credit=%0d want 1 0 25", fault, vend_req, credit);
        end
`ifdef VEND_CHANGE_EN
        checks++;
        if (chg_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_chg_enter got creq=%b busy=%b want 1 1", chg_req, busy);
        end
        chg_ack = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (credit !== 7'(25 - 5 * i) || fault !== 1'b0) begin
                failures++;
                $display("FAIL tmo_refund_%0d got credit=%0d fault=%b want %0d 0", i, credit, fault, 25 - 5 * i);
            end
        end
        chg_ack = 0;
        checks++;
        if (chg_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_refund_end got creq=%b busy=%b want 0 0", chg_req, busy);
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_idle got busy=%b want 0", busy);
        end
        tick();
        checks++;
        if (fault !== 1'b0 || vend_req !== 1'b1 || credit !== 7'd25) begin
            failures++;
            $display("FAIL tmo_revend got fault=%b vreq=%b credit=%0d want 0 1 25", fault, vend_req, credit);
        end
`endif
    endtask

    task automatic test_ack_on_timeout_edge();
        do_reset();
        coin(0, 0, 1);
        tick();
        repeat (15) tick();
        vend_ack = 1;
        tick();
        vend_ack = 0;
        checks++;
        if (fault !== 1'b0 || credit !== 7'd10 || vend_req !== 1'b0) begin
            failures++;
            $display("FAIL ack_wins got fault=%b credit=%0d vreq=%b want 0 10 0", fault, credit, vend_req);
        end
    endtask

    task automatic test_ignored_acks();
        do_reset();
        coin(0, 1, 0);
        vend_ack = 1;
        chg_ack = 1;
        tick();
        tick();
        vend_ack = 0;
        chg_ack = 0;
        checks++;
        if (credit !== 7'd10 || busy !== 1'b0 || vend_req !== 1'b0 || chg_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_acks got credit=%0d busy=%b vreq=%b creq=%b want 10 0 0 0",
                     credit, busy, vend_req, chg_req);
        end
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        test_reset();
        test_basic_vend();
        test_change_after_vend();
        test_coin_reject();
        test_cancel();
        test_timeout();
        test_ack_on_timeout_edge();
        test_ignored_acks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
